// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: runtime baud/parity/stop select, 3-sample majority vote.
// Optional break detection (adds port brk) is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_param #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           baud_set,
    input  logic [1:0]           parity_mode,
    input  logic                 stop2,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic                 brk
`endif
);

    localparam int unsigned SW = $clog2(OVERSAMPLE);
    localparam int unsigned M  = OVERSAMPLE / 2;
    localparam logic [SW-1:0] S_LO   = SW'(M - 1);
    localparam logic [SW-1:0] S_MID  = SW'(M);
    localparam logic [SW-1:0] S_VOTE = SW'(M + 1);
    localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);

    localparam logic [15:0] DIV_9600   = 16'(CLK_HZ / (9600   * OVERSAMPLE) - 1);
    localparam logic [15:0] DIV_19200  = 16'(CLK_HZ / (19200  * OVERSAMPLE) - 1);
    localparam logic [15:0] DIV_38400  = 16'(CLK_HZ / (38400  * OVERSAMPLE) - 1);
    localparam logic [15:0] DIV_57600  = 16'(CLK_HZ / (57600  * OVERSAMPLE) - 1);
    localparam logic [15:0] DIV_115200 = 16'(CLK_HZ / (115200 * OVERSAMPLE) - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rxs_d;
    logic [15:0]            r_div_cnt;
    logic [SW-1:0]          r_s;
    logic [3:0]             r_bit;
    logic                   r_smp0;
    logic                   r_smp1;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_pbit;
    logic                   r_stop_idx;
    logic                   r_ferr_acc;
    logic                   r_arm;
    logic [2:0]             r_baud;
    logic [1:0]             r_par;
    logic                   r_stop2;

    logic        w_rxs;
    logic        w_fall;
    logic        w_tick;
    logic        w_vote;
    logic [15:0] w_div_max;
    logic        w_par_en;
    logic        w_par_x;
    logic        w_pe;
    logic        w_fe;

    assign w_rxs    = r_sync[SYNC_STAGES-1];
    assign w_fall   = r_rxs_d & ~w_rxs;
    assign w_tick   = (r_state != IDLE) && (r_div_cnt == w_div_max);
    assign w_vote   = (r_smp0 & r_smp1) | (r_smp0 & w_rxs) | (r_smp1 & w_rxs);
    assign w_par_en = (r_par == 2'd1) || (r_par == 2'd2);
    assign w_par_x  = (^r_shift) ^ r_pbit;
    assign w_pe     = w_par_en && ((r_par == 2'd1) ? w_par_x : ~w_par_x);
    assign w_fe     = r_ferr_acc | ~w_vote;

    always_comb begin
        w_div_max = DIV_9600;
        case (r_baud)
            3'd1:    w_div_max = DIV_19200;
            3'd2:    w_div_max = DIV_38400;
            3'd3:    w_div_max = DIV_57600;
            3'd4:    w_div_max = DIV_115200;
            default: w_div_max = DIV_9600;
        endcase
    end

`ifdef UART_RX_BREAK_DET_EN
    logic r_stop_hi;
    logic w_brk;
    assign w_brk = (r_shift == '0) && !(w_par_en && r_pbit) && !r_stop_hi && !w_vote;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '1;
            r_rxs_d <= 1'b1;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], rx};
            r_rxs_d <= w_rxs;
        end
    end

    // Counter held at zero while idle so the first tick lands DIV+1 clocks after the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
        end else if (r_state == IDLE || w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_s        <= '0;
            r_bit      <= '0;
            r_smp0     <= 1'b1;
            r_smp1     <= 1'b1;
            r_shift    <= '0;
            r_pbit     <= 1'b0;
            r_stop_idx <= 1'b0;
            r_ferr_acc <= 1'b0;
            r_arm      <= 1'b1;
            r_baud     <= '0;
            r_par      <= '0;
            r_stop2    <= 1'b0;
            data       <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            r_stop_hi  <= 1'b0;
            brk        <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk      <= 1'b0;
`endif
            if (w_rxs) begin
                r_arm <= 1'b1;
            end
            if (w_tick) begin
                r_s <= (r_s == S_END) ? '0 : r_s + 1'b1;
                if (r_s == S_LO)  r_smp0 <= w_rxs;
                if (r_s == S_MID) r_smp1 <= w_rxs;
            end

            case (r_state)
                IDLE: begin
                    if (w_fall && r_arm) begin
                        r_state <= START;
                        busy    <= 1'b1;
                        r_baud  <= baud_set;
                        r_par   <= parity_mode;
                        r_stop2 <= stop2;
                        r_s     <= '0;
                        r_bit   <= '0;
                    end
                end
                START: begin
                    if (w_tick) begin
                        if (r_s == S_VOTE && w_vote) begin
                            r_state <= IDLE;
                            busy    <= 1'b0;
                        end else if (r_s == S_END) begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        if (r_s == S_VOTE) begin
                            r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                        end
                        if (r_s == S_END) begin
                            if (r_bit == 4'(DATA_BITS - 1)) begin
                                r_state    <= w_par_en ? PARITY : STOP;
                                r_stop_idx <= 1'b0;
                                r_ferr_acc <= 1'b0;
                                r_pbit     <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                                r_stop_hi  <= 1'b0;
`endif
                            end else begin
                                r_bit <= r_bit + 4'd1;
                            end
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        if (r_s == S_VOTE) r_pbit  <= w_vote;
                        if (r_s == S_END)  r_state <= STOP;
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        // Final stop bit completes at its vote tick so back-to-back frames can re-arm.
                        if (r_s == S_VOTE && r_stop_idx == r_stop2) begin
                            r_state    <= IDLE;
                            busy       <= 1'b0;
                            data       <= r_shift;
                            frame_err  <= w_fe;
                            parity_err <= w_pe;
                            rx_valid   <= 1'b1;
                            r_arm      <= ~w_fe;
`ifdef UART_RX_BREAK_DET_EN
                            if (w_brk) begin
                                rx_valid  <= 1'b0;
                                frame_err <= 1'b1;
                                brk       <= 1'b1;
                            end
`endif
                        end else if (r_s == S_VOTE) begin
                            r_ferr_acc <= r_ferr_acc | ~w_vote;
`ifdef UART_RX_BREAK_DET_EN
                            r_stop_hi  <= r_stop_hi | w_vote;
`endif
                        end else if (r_s == S_END) begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: table of single frames plus glitch, break, back-to-back and reset sequences.
module tb_uart_rx_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] baud_set = 3'd4;
    logic [1:0] parity_mode = 2'd0;
    logic       stop2 = 1'b0;
    logic       rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

    logic [7:0] a_data, b_data;
    logic [6:0] c_data;
    logic       a_vld, a_fe, a_pe, a_busy;
    logic       b_vld, b_fe, b_pe, b_busy;
    logic       c_vld, c_fe, c_pe, c_busy;
`ifdef UART_RX_BREAK_DET_EN
    logic       a_brk, b_brk, c_brk;
`endif

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_HZ(50_000_000), .OVERSAMPLE(16), .DATA_BITS(8), .SYNC_STAGES(2)) u_a (
        .clk(clk), .rst_n(rst_n), .baud_set(baud_set), .parity_mode(parity_mode), .stop2(stop2),
        .rx(rx_a), .data(a_data), .rx_valid(a_vld), .frame_err(a_fe), .parity_err(a_pe), .busy(a_busy)
`ifdef UART_RX_BREAK_DET_EN
        , .brk(a_brk)
`endif
    );

    uart_rx_param #(.CLK_HZ(1_843_200), .OVERSAMPLE(16), .DATA_BITS(8), .SYNC_STAGES(2)) u_b (
        .clk(clk), .rst_n(rst_n), .baud_set(baud_set), .parity_mode(parity_mode), .stop2(stop2),
        .rx(rx_b), .data(b_data), .rx_valid(b_vld), .frame_err(b_fe), .parity_err(b_pe), .busy(b_busy)
`ifdef UART_RX_BREAK_DET_EN
        , .brk(b_brk)
`endif
    );

    uart_rx_param #(.CLK_HZ(1_843_200), .OVERSAMPLE(16), .DATA_BITS(7), .SYNC_STAGES(3)) u_c (
        .clk(clk), .rst_n(rst_n), .baud_set(baud_set), .parity_mode(parity_mode), .stop2(stop2),
        .rx(rx_c), .data(c_data), .rx_valid(c_vld), .frame_err(c_fe), .parity_err(c_pe), .busy(c_busy)
`ifdef UART_RX_BREAK_DET_EN
        , .brk(c_brk)
`endif
    );

    typedef struct {
        logic [8:0] d;
        logic       fe;
        logic       pe;
    } res_t;

    res_t q_a[$], q_b[$], q_c[$];
    int checks = 0;
    int errors = 0;

    function automatic res_t mk(input logic [8:0] d, input logic fe, input logic pe);
        res_t r;
        r.d = d; r.fe = fe; r.pe = pe;
        return r;
    endfunction

    always @(negedge clk) begin
        if (a_vld) q_a.push_back(mk({1'b0, a_data}, a_fe, a_pe));
        if (b_vld) q_b.push_back(mk({1'b0, b_data}, b_fe, b_pe));
        if (c_vld) q_c.push_back(mk({2'b00, c_data}, c_fe, c_pe));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_rx(input int dut, input logic v);
        case (dut)
            0: rx_a = v;
            1: rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    task automatic hold(input int dut, input logic v, input int n);
        set_rx(dut, v);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int dut, input int cpb, input int nbits, input logic [8:0] d,
                              input logic [1:0] pm, input logic pflip, input logic s2,
                              input logic st1lo, input logic st2lo);
        logic p;
        p = 1'b0;
        hold(dut, 1'b0, cpb);
        for (int i = 0; i < nbits; i++) begin
            hold(dut, d[i], cpb);
            p = p ^ d[i];
        end
        if (pm == 2'd1 || pm == 2'd2) begin
            if (pm == 2'd2) p = ~p;
            hold(dut, p ^ pflip, cpb);
        end
        hold(dut, ~st1lo, cpb);
        if (s2) hold(dut, ~st2lo, cpb);
        set_rx(dut, 1'b1);
    endtask

    function automatic int qsize(input int dut);
        case (dut)
            0: return q_a.size();
            1: return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    task automatic take(input int dut, input string name, input logic [8:0] ed, input logic efe, input logic epe);
        res_t r;
        if (qsize(dut) == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no rx_valid expected data %0h", name, ed);
            return;
        end
        case (dut)
            0: r = q_a.pop_front();
            1: r = q_b.pop_front();
            default: r = q_c.pop_front();
        endcase
        chk({name, " data"}, 32'(r.d), 32'(ed));
        chk({name, " frame_err"}, 32'(r.fe), 32'(efe));
        chk({name, " parity_err"}, 32'(r.pe), 32'(epe));
    endtask

    typedef struct {
        int         dut;
        int         cpb;
        logic [2:0] baud;
        logic [1:0] pm;
        logic       s2;
        logic [8:0] d;
        logic       pflip;
        logic       st1lo;
        logic       st2lo;
        logic [8:0] ed;
        logic       efe;
        logic       epe;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //         dut cpb  baud  pm    s2    d       pflip st1lo st2lo ed      efe   epe
        vecs[0]  = '{0, 432, 3'd4, 2'd0, 1'b0, 9'h0A5, 1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b0};
        vecs[1]  = '{1, 192, 3'd0, 2'd1, 1'b0, 9'h037, 1'b0, 1'b0, 1'b0, 9'h037, 1'b0, 1'b0};
        vecs[2]  = '{1, 192, 3'd0, 2'd1, 1'b0, 9'h037, 1'b1, 1'b0, 1'b0, 9'h037, 1'b0, 1'b1};
        vecs[3]  = '{0, 864, 3'd3, 2'd0, 1'b1, 9'h03C, 1'b0, 1'b0, 1'b1, 9'h03C, 1'b1, 1'b0};
        vecs[4]  = '{1, 16,  3'd4, 2'd2, 1'b0, 9'h001, 1'b1, 1'b0, 1'b0, 9'h001, 1'b0, 1'b1};
        vecs[5]  = '{1, 16,  3'd4, 2'd3, 1'b0, 9'h0FF, 1'b0, 1'b0, 1'b0, 9'h0FF, 1'b0, 1'b0};
        vecs[6]  = '{1, 32,  3'd3, 2'd1, 1'b1, 9'h05A, 1'b0, 1'b0, 1'b0, 9'h05A, 1'b0, 1'b0};
        vecs[7]  = '{1, 192, 3'd6, 2'd0, 1'b0, 9'h0C3, 1'b0, 1'b0, 1'b0, 9'h0C3, 1'b0, 1'b0};
        vecs[8]  = '{1, 96,  3'd1, 2'd0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b0, 9'h000, 1'b1, 1'b0};
        vecs[9]  = '{1, 48,  3'd2, 2'd2, 1'b0, 9'h0FE, 1'b0, 1'b0, 1'b0, 9'h0FE, 1'b0, 1'b0};
        vecs[10] = '{1, 16,  3'd4, 2'd0, 1'b1, 9'h081, 1'b0, 1'b1, 1'b0, 9'h081, 1'b1, 1'b0};

        repeat (4) @(negedge clk);
        chk("reset data", 32'(a_data), 32'h0);
        chk("reset rx_valid", 32'(a_vld), 32'h0);
        chk("reset frame_err", 32'(a_fe), 32'h0);
        chk("reset parity_err", 32'(a_pe), 32'h0);
        chk("reset busy", 32'(a_busy), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            baud_set    = vecs[i].baud;
            parity_mode = vecs[i].pm;
            stop2       = vecs[i].s2;
            hold(vecs[i].dut, 1'b1, 2 * vecs[i].cpb);
            send_frame(vecs[i].dut, vecs[i].cpb, 8, vecs[i].d, vecs[i].pm, vecs[i].pflip,
                       vecs[i].s2, vecs[i].st1lo, vecs[i].st2lo);
            hold(vecs[i].dut, 1'b1, 2 * vecs[i].cpb);
            chk($sformatf("v%0d count", i), 32'(qsize(vecs[i].dut)), 32'd1);
            take(vecs[i].dut, $sformatf("v%0d", i), vecs[i].ed, vecs[i].efe, vecs[i].epe);
            chk($sformatf("v%0d busy idle", i), 32'(vecs[i].dut == 0 ? a_busy : b_busy), 32'd0);
        end

        // Three-tick low glitch at 115200 on the 50 MHz instance.
        baud_set = 3'd4; parity_mode = 2'd0; stop2 = 1'b0;
        hold(0, 1'b0, 40);
        chk("glitch busy high", 32'(a_busy), 32'd1);
        hold(0, 1'b0, 41);
        set_rx(0, 1'b1);
        begin
            int n;
            n = 0;
            while (a_busy && n < 351) begin
                @(negedge clk);
                n++;
            end
            chk("glitch busy drop", 32'(a_busy), 32'd0);
        end
        hold(0, 1'b1, 864);
        chk("glitch no rx_valid", 32'(qsize(0)), 32'd0);
        send_frame(0, 432, 8, 9'h081, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(0, 1'b1, 864);
        chk("post-glitch count", 32'(qsize(0)), 32'd1);
        take(0, "post-glitch", 9'h081, 1'b0, 1'b0);

        // Back-to-back 7-bit odd-parity frames with no idle gap.
        baud_set = 3'd0; parity_mode = 2'd2; stop2 = 1'b0;
        hold(2, 1'b1, 384);
        send_frame(2, 192, 7, 9'h055, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(2, 192, 7, 9'h02A, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(2, 1'b1, 384);
        chk("b2b count", 32'(qsize(2)), 32'd2);
        take(2, "b2b first", 9'h055, 1'b0, 1'b0);
        take(2, "b2b second", 9'h02A, 1'b0, 1'b0);

        // Break: line held low well past the stop bit must give exactly one frame.
        baud_set = 3'd4; parity_mode = 2'd0; stop2 = 1'b0;
        hold(1, 1'b1, 32);
        send_frame(1, 16, 8, 9'h000, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        hold(1, 1'b0, 160);
        chk("break busy while low", 32'(b_busy), 32'd0);
        hold(1, 1'b1, 48);
        chk("break count", 32'(qsize(1)), 32'd1);
        take(1, "break", 9'h000, 1'b1, 1'b0);
        send_frame(1, 16, 8, 9'h042, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(1, 1'b1, 48);
        take(1, "after break", 9'h042, 1'b0, 1'b0);

        // Reset in the middle of a 0xFF frame on the 50 MHz instance.
        baud_set = 3'd4; parity_mode = 2'd0; stop2 = 1'b0;
        hold(0, 1'b0, 432);
        hold(0, 1'b1, 1296);
        chk("midframe busy", 32'(a_busy), 32'd1);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midreset data", 32'(a_data), 32'h0);
        chk("midreset rx_valid", 32'(a_vld), 32'h0);
        chk("midreset frame_err", 32'(a_fe), 32'h0);
        chk("midreset parity_err", 32'(a_pe), 32'h0);
        chk("midreset busy", 32'(a_busy), 32'h0);
        repeat (7) @(negedge clk);
        rst_n = 1'b1;
        hold(0, 1'b1, 864);
        send_frame(0, 432, 8, 9'h012, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        hold(0, 1'b1, 864);
        chk("post-reset count", 32'(qsize(0)), 32'd1);
        take(0, "post-reset", 9'h012, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
